// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default address window for the APB master bridge.
package apb_master_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Peripheral window: UART base through end of the DEBUG region
   localparam logic [31:0] WIN_START_DEFAULT = 32'h1A10_0000;
   localparam logic [31:0] WIN_END_DEFAULT   = 32'h1A11_7FFF;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles without pready; flags expiry one cycle before the limit is reached.
module apb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   logic [CNT_W-1:0] cnt;

   assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(LIMIT));

   // Saturating so a disabled timeout never wraps
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && !expired && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Converts a single-outstanding req/gnt/rvalid interface into APB3 SETUP/ACCESS transfers
// with address-window checking and a pready timeout.
module apb_master_bridge
   import apb_master_bridge_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter logic [31:0] WIN_START      = WIN_START_DEFAULT,
   parameter logic [31:0] WIN_END        = WIN_END_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_i,
   input  logic [31:0]               addr_i,
   input  logic                      we_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
   output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
   output logic                      apb_pwrite,
   output logic                      apb_psel,
   output logic                      apb_penable,
   input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
   input  logic                      apb_pready,
   input  logic                      apb_pslverr
);

   state_e state;
   logic   in_win;
   logic   expired;

   assign in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);
   assign gnt_o  = req_i && (state == IDLE);

   apb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == SETUP),
      .enable  ((state == ACCESS) && !apb_pready),
      .expired (expired)
   );

   // Transfer sequencer; APB and response outputs are registered on state entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         apb_paddr   <= '0;
         apb_pwdata  <= '0;
         apb_pwrite  <= 1'b0;
         apb_psel    <= 1'b0;
         apb_penable <= 1'b0;
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rvalid_o <= 1'b0;
               rdata_o  <= '0;
               err_o    <= 1'b0;
               if (req_i) begin
                  if (in_win) begin
                     apb_paddr  <= addr_i[APB_ADDR_WIDTH-1:0];
                     apb_pwdata <= wdata_i;
                     apb_pwrite <= we_i;
                     apb_psel   <= 1'b1;
                     state      <= SETUP;
                  end else begin
                     rvalid_o <= 1'b1;
                     err_o    <= 1'b1;
                     state    <= RESP;
                  end
               end
            end
            SETUP: begin
               apb_penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over a coincident timeout
               if (apb_pready) begin
                  apb_psel    <= 1'b0;
                  apb_penable <= 1'b0;
                  rvalid_o    <= 1'b1;
                  err_o       <= apb_pslverr;
                  rdata_o     <= apb_pwrite ? '0 : apb_prdata;
                  state       <= RESP;
               end else if (expired) begin
                  apb_psel    <= 1'b0;
                  apb_penable <= 1'b0;
                  rvalid_o    <= 1'b1;
                  err_o       <= 1'b1;
                  rdata_o     <= '0;
                  state       <= RESP;
               end
            end
            RESP: begin
               rvalid_o <= 1'b0;
               rdata_o  <= '0;
               err_o    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: stimulus queues expected responses, a monitor checks rvalid.
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [31:0] apb_paddr;
   logic [31:0] apb_pwdata;
   logic        apb_pwrite;
   logic        apb_psel;
   logic        apb_penable;
   logic [31:0] apb_prdata;
   logic        apb_pready;
   logic        apb_pslverr;

   int n_chk  = 0;
   int n_fail = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   apb_master_bridge #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .apb_paddr   (apb_paddr),
      .apb_pwdata  (apb_pwdata),
      .apb_pwrite  (apb_pwrite),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_prdata  (apb_prdata),
      .apb_pready  (apb_pready),
      .apb_pslverr (apb_pslverr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every rvalid must match the oldest queued expectation
   always @(negedge clk) begin
      if (rvalid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid_o), 32'h0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rdata_o, e[32:1]);
            chk("rsp_err", 32'(err_o), 32'(e[0]));
         end
      end
   end

   // One transfer: nacc ACCESS cycles expected; pready raised on the last one when rdy_end
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input int nacc, input logic rdy_end, input logic [31:0] prd,
                       input logic slv, input logic inwin,
                       input logic [31:0] exp_rd, input logic exp_err);
      @(negedge clk);
      req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
      #1 chk("gnt", 32'(gnt_o), 32'h1);
      exp_q.push_back({exp_rd, exp_err});
      @(negedge clk);
      req_i = 1'b0; addr_i = 32'h0; we_i = ~w; wdata_i = 32'h0;
      if (inwin) begin
         chk("setup_psel", 32'(apb_psel), 32'h1);
         chk("setup_penable", 32'(apb_penable), 32'h0);
         chk("setup_paddr", apb_paddr, a);
         for (int k = 0; k < nacc; k++) begin
            @(negedge clk);
            chk("acc_psel", 32'(apb_psel), 32'h1);
            chk("acc_penable", 32'(apb_penable), 32'h1);
            chk("acc_paddr", apb_paddr, a);
            chk("acc_pwrite", 32'(apb_pwrite), 32'(w));
            if (w) chk("acc_pwdata", apb_pwdata, wd);
            chk("acc_no_rvalid", 32'(rvalid_o), 32'h0);
            apb_pready  = (k == nacc - 1) && rdy_end;
            apb_prdata  = prd;
            apb_pslverr = slv;
         end
         @(negedge clk);
         apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'h0;
         chk("resp_psel", 32'(apb_psel), 32'h0);
         chk("resp_penable", 32'(apb_penable), 32'h0);
      end else begin
         chk("oow_psel", 32'(apb_psel), 32'h0);
      end
      chk("resp_rvalid", 32'(rvalid_o), 32'h1);
      @(negedge clk);
      chk("idle_rvalid", 32'(rvalid_o), 32'h0);
      chk("idle_rdata", rdata_o, 32'h0);
      chk("idle_err", 32'(err_o), 32'h0);
      chk("idle_psel", 32'(apb_psel), 32'h0);
   endtask

   initial begin
      rst = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
      apb_prdata = '0; apb_pready = 1'b0; apb_pslverr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_psel", 32'(apb_psel), 32'h0);
      chk("rst_penable", 32'(apb_penable), 32'h0);
      chk("rst_pwrite", 32'(apb_pwrite), 32'h0);
      chk("rst_paddr", apb_paddr, 32'h0);
      chk("rst_pwdata", apb_pwdata, 32'h0);
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      rst = 1'b0;

      // Zero-wait write
      xfer(32'h1A10_1000, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      // Wait-state read; pready on the 4th ACCESS cycle also coincides with the timeout
      xfer(32'h1A10_3004, 1'b0, 32'h0, 4, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      // Slave error on write: rdata forced to 0
      xfer(32'h1A10_2000, 1'b1, 32'h5555_AAAA, 1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b1);
      // Slave error on read: read data still returned
      xfer(32'h1A10_2004, 1'b0, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
      // Out of window
      xfer(32'h1A20_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      // Window boundaries
      xfer(32'h1A10_0000, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 32'h0000_0011, 1'b0);
      xfer(32'h1A11_7FFF, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 32'h0000_0022, 1'b0);
      xfer(32'h1A0F_FFFF, 1'b1, 32'h1, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      xfer(32'h1A11_8000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      // Timeout abort after exactly 4 ACCESS cycles
      xfer(32'h1A10_4000, 1'b0, 32'h0, 4, 1'b0, 32'h7777_7777, 1'b0, 1'b1, 32'h0, 1'b1);
      // Write completing on the last allowed cycle
      xfer(32'h1A10_4004, 1'b1, 32'h0BAD_CAFE, 4, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 32'h0, 1'b0);

      // Reset during ACCESS wait states: no response may appear
      @(negedge clk);
      req_i = 1'b1; addr_i = 32'h1A10_5000; we_i = 1'b0;
      #1 chk("rstmid_gnt", 32'(gnt_o), 32'h1);
      @(negedge clk);
      req_i = 1'b0; apb_pready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_acc_penable", 32'(apb_penable), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_psel", 32'(apb_psel), 32'h0);
      chk("rstmid_penable", 32'(apb_penable), 32'h0);
      chk("rstmid_rvalid", 32'(rvalid_o), 32'h0);
      rst = 1'b0;
      xfer(32'h1A10_6000, 1'b1, 32'h0123_4567, 1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
